// File: rtl/hex_scroller_pkg.sv
// Shared definitions for the hex scroller: character codes, segment patterns,
// FSM state encoding and the code-to-segment decoder.
// Optional feature macro: HEX_SCROLLER_DP_EN (per-character decimal point).
package hex_scroller_pkg;

    // Character codes; 0..15 are the hex digits themselves
    localparam logic [4:0] CH_H     = 5'd16;
    localparam logic [4:0] CH_E     = 5'd17;
    localparam logic [4:0] CH_L     = 5'd18;
    localparam logic [4:0] CH_P     = 5'd19;
    localparam logic [4:0] CH_U     = 5'd20;
    localparam logic [4:0] CH_DASH  = 5'd21;
    localparam logic [4:0] CH_BLANK = 5'd31;

    // Active-low {dp,g,f,e,d,c,b,a} patterns with dp off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_H     = 8'h89;
    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_P     = 8'h8C;
    localparam logic [7:0] SEG_U     = 8'hC1;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Number of digits on the display
    localparam int unsigned NUM_DIGITS = 6;

    // One buffered character as carried through the FIFO
    typedef struct packed {
`ifdef HEX_SCROLLER_DP_EN
        logic       dp;
`endif
        logic [4:0] code;
    } char_t;

    localparam int unsigned CHAR_W = $bits(char_t);

    // Code to active-low {g..a}; unlisted codes show blank
    function automatic logic [6:0] seg7_encode(input logic [4:0] code);
        logic [7:0] seg;
        case (code)
            5'd0:     seg = SEG_0;
            5'd1:     seg = SEG_1;
            5'd2:     seg = SEG_2;
            5'd3:     seg = SEG_3;
            5'd4:     seg = SEG_4;
            5'd5:     seg = SEG_5;
            5'd6:     seg = SEG_6;
            5'd7:     seg = SEG_7;
            5'd8:     seg = SEG_8;
            5'd9:     seg = SEG_9;
            5'd10:    seg = SEG_A;
            5'd11:    seg = SEG_B;
            5'd12:    seg = SEG_C;
            5'd13:    seg = SEG_D;
            5'd14:    seg = SEG_E;
            5'd15:    seg = SEG_F;
            CH_H:     seg = SEG_H;
            CH_E:     seg = SEG_E;
            CH_L:     seg = SEG_L;
            CH_P:     seg = SEG_P;
            CH_U:     seg = SEG_U;
            CH_DASH:  seg = SEG_DASH;
            default:  seg = SEG_BLANK;
        endcase
        return seg[6:0];
    endfunction

endpackage

// File: rtl/hex_scroller_if.sv
// Character handshake between a letter-sequencing FSM and the hex scroller.
// Optional feature macro: HEX_SCROLLER_DP_EN adds char_dp.
interface hex_scroller_if;
    logic       char_valid;
    logic [4:0] char_code;
`ifdef HEX_SCROLLER_DP_EN
    logic       char_dp;
`endif
    logic       char_ready;

`ifdef HEX_SCROLLER_DP_EN
    modport master (output char_valid, output char_code, output char_dp, input char_ready);
    modport slave  (input char_valid, input char_code, input char_dp, output char_ready);
`else
    modport master (output char_valid, output char_code, input char_ready);
    modport slave  (input char_valid, input char_code, output char_ready);
`endif
endinterface

// File: rtl/scroll_char_fifo.sv
// Small synchronous FIFO; head entry is presented combinationally on dout.
module scroll_char_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra wrap bit distinguishes full from empty
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/hex_scroller.sv
// Buffers character codes and scrolls them right-to-left across HEX5..HEX0,
// one digit per slow tick.
// Optional feature macro: HEX_SCROLLER_DP_EN (per-character decimal point).
module hex_scroller
    import hex_scroller_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    hex_scroller_if.slave        chr,
    input  logic                 hold,
    output logic                 busy,
    output logic [7:0]           HEX0,
    output logic [7:0]           HEX1,
    output logic [7:0]           HEX2,
    output logic [7:0]           HEX3,
    output logic [7:0]           HEX4,
    output logic [7:0]           HEX5
);
    localparam int unsigned CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]  BLANK_ALL = 3'(NUM_DIGITS);

    logic [1:0]       state, state_nxt;
    logic [2:0]       blank_cnt, blank_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic [7:0]       digit [NUM_DIGITS];
    logic             tick_c;
    logic             push_c;
    logic             pop_c;
    logic             fifo_full;
    logic             fifo_empty;
    char_t            in_char;
    char_t            head;
    logic [CHAR_W-1:0] fifo_dout;

    // Incoming character payload
    always_comb begin
        in_char      = '0;
        in_char.code = chr.char_code;
`ifdef HEX_SCROLLER_DP_EN
        in_char.dp   = chr.char_dp;
`endif
    end

    assign head           = char_t'(fifo_dout);
    assign chr.char_ready = !fifo_full;
    assign push_c         = chr.char_valid && !fifo_full;
    assign tick_c         = (state != ST_IDLE) && !hold && (tick_cnt == TICK_LAST);
    assign pop_c          = tick_c && !fifo_empty;

    scroll_char_fifo #(
        .WIDTH (CHAR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .push  (push_c),
        .pop   (pop_c),
        .din   (CHAR_W'(in_char)),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Display value of the popped head character
    function automatic logic [7:0] head_digit(input char_t c);
`ifdef HEX_SCROLLER_DP_EN
        return {~c.dp, seg7_encode(c.code)};
`else
        return {1'b1, seg7_encode(c.code)};
`endif
    endfunction

    // Next-state logic: run while characters arrive, flush six blanks, then idle
    always_comb begin
        state_nxt = state;
        blank_nxt = blank_cnt;
        case (state)
            ST_IDLE: begin
                blank_nxt = 3'd0;
                if (push_c) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (tick_c) begin
                    if (!fifo_empty) begin
                        blank_nxt = 3'd0;
                    end else begin
                        state_nxt = ST_FLUSH;
                        blank_nxt = 3'd1;
                    end
                end
            end
            ST_FLUSH: begin
                if (tick_c) begin
                    if (!fifo_empty) begin
                        state_nxt = ST_RUN;
                        blank_nxt = 3'd0;
                    end else begin
                        blank_nxt = blank_cnt + 3'd1;
                        if (blank_nxt == BLANK_ALL) state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                blank_nxt = 3'd0;
            end
        endcase
    end

    // State, blank counter and busy flag
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            blank_cnt <= 3'd0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_nxt;
            busy      <= (state_nxt != ST_IDLE);
        end
    end

    // Scroll tick divider, held at zero while idle
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_cnt <= '0;
        end else if (state == ST_IDLE) begin
            tick_cnt <= '0;
        end else if (!hold) begin
            tick_cnt <= tick_c ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    // Digit shift register; HEX0 takes the popped char or blank
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= SEG_BLANK;
        end else if (tick_c) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) digit[i] <= digit[i-1];
            digit[0] <= pop_c ? head_digit(head) : SEG_BLANK;
        end
    end

    assign HEX0 = digit[0];
    assign HEX1 = digit[1];
    assign HEX2 = digit[2];
    assign HEX3 = digit[3];
    assign HEX4 = digit[4];
    assign HEX5 = digit[5];
endmodule

// File: tb/tb_hex_scroller.sv
// Directed bench for hex_scroller with TICK_DIV = 4, FIFO_DEPTH = 8.
module tb_hex_scroller;
    logic       CLOCK_50;
    logic       RESET_N;
    logic       hold;
    logic       busy;
    logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    int         checks;
    int         errors;

    hex_scroller_if chr_if ();

    hex_scroller #(
        .TICK_DIV   (4),
        .FIFO_DEPTH (8)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .chr      (chr_if),
        .hold     (hold),
        .busy     (busy),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] hexes();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET_N = 1'b0;
        hold = 1'b0;
        chr_if.char_valid = 1'b0;
        chr_if.char_code  = 5'd0;
`ifdef HEX_SCROLLER_DP_EN
        chr_if.char_dp = 1'b0;
`endif

        // Scenario 1: reset state, then quiet idle
        cyc(3);
        chk("rst_hex",   hexes(), 48'hFFFF_FFFF_FFFF);
        chk("rst_ready", 48'(chr_if.char_ready), 48'd1);
        chk("rst_busy",  48'(busy), 48'd0);
        RESET_N = 1'b1;
        cyc(20);
        chk("idle_hex",  hexes(), 48'hFFFF_FFFF_FFFF);
        chk("idle_busy", 48'(busy), 48'd0);

        // Scenario 2: H E L L 0 back-to-back
        chr_if.char_valid = 1'b1;
        chr_if.char_code  = 5'd16;
        cyc(1);
        chk("s2_busy", 48'(busy), 48'd1);
        chr_if.char_code = 5'd17;
        cyc(1);
        chr_if.char_code = 5'd18;
        cyc(1);
        chr_if.char_code = 5'd18;
        cyc(1);
        chr_if.char_code = 5'd0;
        chk("s2_hex0_pre", 48'(HEX0), 48'hFF);
        cyc(1);
        chr_if.char_valid = 1'b0;
        chk("s2_first_h", hexes(), 48'hFFFF_FFFF_FF89);
        cyc(16);
        chk("s2_hello", hexes(), 48'hFF89_86C7_C7C0);

        // Scenario 3: drain to blank, return to idle
        cyc(4);
        chk("s3_tick6", hexes(), 48'h8986_C7C7_C0FF);
        chk("s3_flush", 48'(dut.state), 48'd2);
        cyc(20);
        chk("s3_blank", hexes(), 48'hFFFF_FFFF_FFFF);
        chk("s3_busy",  48'(busy), 48'd0);
        chk("s3_cnt",   48'(dut.tick_cnt), 48'd0);
        cyc(8);
        chk("s3_stay", hexes(), 48'hFFFF_FFFF_FFFF);

        // Scenario 4: fill FIFO under hold, ninth push refused
        hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chr_if.char_valid = 1'b1;
            chr_if.char_code  = 5'(i);
            chk("s4_ready_in", 48'(chr_if.char_ready), (i < 8) ? 48'd1 : 48'd0);
            cyc(1);
        end
        chr_if.char_valid = 1'b0;
        chk("s4_full",   48'(chr_if.char_ready), 48'd0);
        chk("s4_busy",   48'(busy), 48'd1);
        chk("s4_frozen", hexes(), 48'hFFFF_FFFF_FFFF);
        cyc(5);
        chk("s4_hold_cnt", 48'(dut.tick_cnt), 48'd0);
        chk("s4_hold_hex", hexes(), 48'hFFFF_FFFF_FFFF);
        hold = 1'b0;
        cyc(3);
        chk("s4_tick",       48'(dut.tick_c), 48'd1);
        chk("s4_ready_tick", 48'(chr_if.char_ready), 48'd0);
        cyc(1);
        chk("s4_ready_after", 48'(chr_if.char_ready), 48'd1);
        chk("s4_pop0", 48'(HEX0), 48'hC0);
        cyc(28);
        chk("s4_codes", hexes(), 48'hA4B0_9992_82F8);
        cyc(4);
        chk("s4_no9th", hexes(), 48'hB099_9282_F8FF);
        cyc(4);
        chk("s5_blank2", 48'(dut.blank_cnt), 48'd2);
        chk("s5_hex_pre", hexes(), 48'h9992_82F8_FFFF);

        // Scenario 5: push dash mid-flush
        chr_if.char_valid = 1'b1;
        chr_if.char_code  = 5'd21;
        cyc(1);
        chr_if.char_valid = 1'b0;
        cyc(3);
        chk("s5_dash",  hexes(), 48'h9282_F8FF_FFBF);
        chk("s5_state", 48'(dut.state), 48'd1);
        chk("s5_busy",  48'(busy), 48'd1);

        // Scenario 6: async reset mid-run with three queued chars
        for (int i = 1; i <= 3; i++) begin
            chr_if.char_valid = 1'b1;
            chr_if.char_code  = 5'(i);
            cyc(1);
        end
        chr_if.char_valid = 1'b0;
        chk("s6_queued", 48'(dut.fifo_empty), 48'd0);
        chk("s6_cnt",    48'(dut.tick_cnt), 48'd3);
        #2 RESET_N = 1'b0;
        #1;
        chk("s6_hex",   hexes(), 48'hFFFF_FFFF_FFFF);
        chk("s6_busy",  48'(busy), 48'd0);
        chk("s6_empty", 48'(dut.fifo_empty), 48'd1);
        chk("s6_ready", 48'(chr_if.char_ready), 48'd1);
        #9 RESET_N = 1'b1;
        cyc(9);
        chk("s6_after_hex",   hexes(), 48'hFFFF_FFFF_FFFF);
        chk("s6_after_state", 48'(dut.state), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
